// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the writeback-stage register file block.
// Status codes, register IDs and the W pipeline register payload live here only.
package wb_regfile_pkg;

  localparam int unsigned REG_W  = 64;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STAT_W = 4;
  localparam int unsigned NREGS  = 15;

  localparam logic [STAT_W-1:0] SBUB = STAT_W'(0);
  localparam logic [STAT_W-1:0] SAOK = STAT_W'(1);
  localparam logic [STAT_W-1:0] SHLT = STAT_W'(2);
  localparam logic [STAT_W-1:0] SADR = STAT_W'(3);
  localparam logic [STAT_W-1:0] SINS = STAT_W'(4);

  localparam logic [ID_W-1:0] RRAX  = ID_W'(0);
  localparam logic [ID_W-1:0] RRCX  = ID_W'(1);
  localparam logic [ID_W-1:0] RRDX  = ID_W'(2);
  localparam logic [ID_W-1:0] RRBX  = ID_W'(3);
  localparam logic [ID_W-1:0] RRSP  = ID_W'(4);
  localparam logic [ID_W-1:0] RRBP  = ID_W'(5);
  localparam logic [ID_W-1:0] RRSI  = ID_W'(6);
  localparam logic [ID_W-1:0] RRDI  = ID_W'(7);
  localparam logic [ID_W-1:0] RR8   = ID_W'(8);
  localparam logic [ID_W-1:0] RR9   = ID_W'(9);
  localparam logic [ID_W-1:0] RR10  = ID_W'(10);
  localparam logic [ID_W-1:0] RR11  = ID_W'(11);
  localparam logic [ID_W-1:0] RR12  = ID_W'(12);
  localparam logic [ID_W-1:0] RR13  = ID_W'(13);
  localparam logic [ID_W-1:0] RR14  = ID_W'(14);
  localparam logic [ID_W-1:0] RNONE = ID_W'(15);

  typedef struct packed {
    logic [STAT_W-1:0] stat;
    logic [REG_W-1:0]  val_e;
    logic [REG_W-1:0]  val_m;
    logic [ID_W-1:0]   dst_e;
    logic [ID_W-1:0]   dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{stat: SBUB, val_e: '0, val_m: '0, dst_e: RNONE, dst_m: RNONE};

  // Statuses that permit the retiring instruction to write back.
  function automatic logic stat_writes(input logic [STAT_W-1:0] s);
    return (s == SAOK) || (s == SBUB);
  endfunction

  // Statuses that stop the machine when they reach writeback.
  function automatic logic stat_halts(input logic [STAT_W-1:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the memory/decode stages and the writeback register file.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic [STAT_W-1:0] M_stat_i;
  logic [REG_W-1:0]  M_valE_i;
  logic [REG_W-1:0]  m_valM_i;
  logic [ID_W-1:0]   M_dstE_i;
  logic [ID_W-1:0]   M_dstM_i;
  logic              W_stall_i;
  logic              W_bubble_i;
  logic [ID_W-1:0]   d_srcA_i;
  logic [ID_W-1:0]   d_srcB_i;
  logic [REG_W-1:0]  d_rvalA_o;
  logic [REG_W-1:0]  d_rvalB_o;
  logic [REG_W-1:0]  W_valE_o;
  logic [REG_W-1:0]  W_valM_o;
  logic [ID_W-1:0]   W_dstE_o;
  logic [ID_W-1:0]   W_dstM_o;
  logic [STAT_W-1:0] W_stat_o;
  logic              halted_o;

  modport slave (
    input  M_stat_i, M_valE_i, m_valM_i, M_dstE_i, M_dstM_i,
    input  W_stall_i, W_bubble_i, d_srcA_i, d_srcB_i,
    output d_rvalA_o, d_rvalB_o, W_valE_o, W_valM_o,
    output W_dstE_o, W_dstM_o, W_stat_o, halted_o
  );

  modport master (
    output M_stat_i, M_valE_i, m_valM_i, M_dstE_i, M_dstM_i,
    output W_stall_i, W_bubble_i, d_srcA_i, d_srcB_i,
    input  d_rvalA_o, d_rvalB_o, W_valE_o, W_valM_o,
    input  W_dstE_o, W_dstM_o, W_stat_o, halted_o
  );

endinterface

// File: rtl/wb_regfile_core.sv
// 15x64 register array with two write ports (M port wins) and two combinational reads.
// Define REGFILE_BYPASS_EN to forward write-pending values to the read ports.
module regfile_core
  import wb_regfile_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_e,
  input  logic [ID_W-1:0]  dst_e,
  input  logic [REG_W-1:0] val_e,
  input  logic             we_m,
  input  logic [ID_W-1:0]  dst_m,
  input  logic [REG_W-1:0] val_m,
  input  logic [ID_W-1:0]  src_a,
  input  logic [ID_W-1:0]  src_b,
  output logic [REG_W-1:0] rval_a,
  output logic [REG_W-1:0] rval_b
);

  logic [REG_W-1:0] regs_q [NREGS];
  logic [REG_W-1:0] regs_d [NREGS];

  // M port applied last so it overrides E on a shared destination.
  always_comb begin
    regs_d = regs_q;
    if (we_e && dst_e != RNONE) regs_d[dst_e] = val_e;
    if (we_m && dst_m != RNONE) regs_d[dst_m] = val_m;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [REG_W-1:0] rd(input logic [ID_W-1:0] src);
    logic [REG_W-1:0] v;
    v = '0;
    if (src != RNONE) begin
`ifdef REGFILE_BYPASS_EN
      if (we_m && src == dst_m)      v = val_m;
      else if (we_e && src == dst_e) v = val_e;
      else                           v = regs_q[src];
`else
      v = regs_q[src];
`endif
    end
    return v;
  endfunction

  always_comb begin
    rval_a = rd(src_a);
    rval_b = rd(src_b);
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: W pipeline register, sticky halt flag, and the register file.
// Optional read bypass of the pending W write is enabled by REGFILE_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  wb_regfile_if.slave   bus
);

  w_reg_t w_q, w_d;
  logic   halted_q, halted_d;
  logic   wr_ok;

  // Stall beats bubble; otherwise capture the memory stage.
  always_comb begin
    w_d = w_q;
    if (!bus.W_stall_i) begin
      if (bus.W_bubble_i) begin
        w_d = W_BUBBLE;
      end else begin
        w_d.stat  = bus.M_stat_i;
        w_d.val_e = bus.M_valE_i;
        w_d.val_m = bus.m_valM_i;
        w_d.dst_e = bus.M_dstE_i;
        w_d.dst_m = bus.M_dstM_i;
      end
    end
  end

  always_comb begin
    wr_ok    = !halted_q && stat_writes(w_q.stat);
    halted_d = halted_q || stat_halts(w_q.stat);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_q      <= W_BUBBLE;
      halted_q <= 1'b0;
    end else begin
      w_q      <= w_d;
      halted_q <= halted_d;
    end
  end

  regfile_core u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_e   (wr_ok),
    .dst_e  (w_q.dst_e),
    .val_e  (w_q.val_e),
    .we_m   (wr_ok),
    .dst_m  (w_q.dst_m),
    .val_m  (w_q.val_m),
    .src_a  (bus.d_srcA_i),
    .src_b  (bus.d_srcB_i),
    .rval_a (bus.d_rvalA_o),
    .rval_b (bus.d_rvalB_o)
  );

  assign bus.W_stat_o = w_q.stat;
  assign bus.W_valE_o = w_q.val_e;
  assign bus.W_valM_o = w_q.val_m;
  assign bus.W_dstE_o = w_q.dst_e;
  assign bus.W_dstM_o = w_q.dst_m;
  assign bus.halted_o = halted_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default build or REGFILE_BYPASS_EN).
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_set(input logic [3:0] stat, input logic [3:0] dste, input logic [63:0] vale,
                       input logic [3:0] dstm, input logic [63:0] valm);
    bus.M_stat_i = stat;
    bus.M_dstE_i = dste;
    bus.M_valE_i = vale;
    bus.M_dstM_i = dstm;
    bus.m_valM_i = valm;
  endtask

  task automatic m_idle();
    m_set(SBUB, RNONE, 64'h0, RNONE, 64'h0);
  endtask

  initial begin
    bus.W_stall_i  = 1'b0;
    bus.W_bubble_i = 1'b0;
    bus.d_srcA_i   = RNONE;
    bus.d_srcB_i   = RNONE;
    m_idle();

    // Reset state
    #12;
    for (int i = 0; i < 15; i++) begin
      bus.d_srcA_i = 4'(i);
      #1;
      check($sformatf("rst_reg%0d", i), bus.d_rvalA_o, 64'h0);
    end
    check("rst_rnone_read", bus.d_rvalB_o, 64'h0);
    check("rst_halted", 64'(bus.halted_o), 64'h0);
    check("rst_dstE", 64'(bus.W_dstE_o), 64'hF);
    check("rst_dstM", 64'(bus.W_dstM_o), 64'hF);
    check("rst_stat", 64'(bus.W_stat_o), 64'(SBUB));
    @(negedge clk);
    rst = 1'b0;

    // Single E-port write, two-edge latency
    m_set(SAOK, 4'd3, 64'h1234, RNONE, 64'h0);
    bus.d_srcA_i = 4'd3;
    tick();
    m_idle();
    check("w_dstE_after1", 64'(bus.W_dstE_o), 64'h3);
    check("w_valE_after1", bus.W_valE_o, 64'h1234);
`ifdef REGFILE_BYPASS_EN
    check("read3_after1", bus.d_rvalA_o, 64'h1234);
`else
    check("read3_after1", bus.d_rvalA_o, 64'h0);
`endif
    tick();
    check("read3_after2", bus.d_rvalA_o, 64'h1234);

    // Same destination on both ports: M wins
    m_set(SAOK, 4'd5, 64'hAA, 4'd5, 64'hBB);
    tick();
    m_idle();
    tick();
    bus.d_srcA_i = 4'd5;
    bus.d_srcB_i = 4'd3;
    #1;
    check("reg5_m_wins", bus.d_rvalA_o, 64'hBB);
    check("reg3_kept", bus.d_rvalB_o, 64'h1234);

    // Stall over bubble, then bubble alone
    m_set(SAOK, 4'd8, 64'h88, 4'd9, 64'h99);
    tick();
    bus.W_stall_i  = 1'b1;
    bus.W_bubble_i = 1'b1;
    m_set(SAOK, 4'd10, 64'hCC, 4'd11, 64'hDD);
    repeat (3) tick();
    check("stall_dstE", 64'(bus.W_dstE_o), 64'h8);
    check("stall_valE", bus.W_valE_o, 64'h88);
    check("stall_dstM", 64'(bus.W_dstM_o), 64'h9);
    check("stall_valM", bus.W_valM_o, 64'h99);
    check("stall_stat", 64'(bus.W_stat_o), 64'(SAOK));
    bus.d_srcA_i = 4'd8;
    bus.d_srcB_i = 4'd9;
    #1;
    check("stall_reg8", bus.d_rvalA_o, 64'h88);
    check("stall_reg9", bus.d_rvalB_o, 64'h99);
    bus.W_stall_i = 1'b0;
    tick();
    check("bubble_stat", 64'(bus.W_stat_o), 64'(SBUB));
    check("bubble_dstE", 64'(bus.W_dstE_o), 64'hF);
    check("bubble_dstM", 64'(bus.W_dstM_o), 64'hF);
    check("bubble_valE", bus.W_valE_o, 64'h0);
    bus.W_bubble_i = 1'b0;
    m_idle();
    tick();
    bus.d_srcA_i = 4'd10;
    bus.d_srcB_i = 4'd11;
    #1;
    check("bubble_reg10", bus.d_rvalA_o, 64'h0);
    check("bubble_reg11", bus.d_rvalB_o, 64'h0);

    // Halt suppresses its own and later writes
    m_set(SAOK, 4'd2, 64'h22, 4'd4, 64'h44);
    tick();
    m_set(SHLT, 4'd2, 64'h77, RNONE, 64'h0);
    tick();
    check("pre_halt", 64'(bus.halted_o), 64'h0);
    m_set(SAOK, 4'd4, 64'h4444, RNONE, 64'h0);
    tick();
    check("halt_set", 64'(bus.halted_o), 64'h1);
    check("halt_w_continues", 64'(bus.W_dstE_o), 64'h4);
    m_idle();
    tick();
    bus.d_srcA_i = 4'd2;
    bus.d_srcB_i = 4'd4;
    #1;
    check("halt_reg2", bus.d_rvalA_o, 64'h22);
    check("halt_reg4", bus.d_rvalB_o, 64'h44);
    tick();
    check("halt_sticky", 64'(bus.halted_o), 64'h1);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_clears_halt", 64'(bus.halted_o), 64'h0);
    check("rst_clears_reg2", bus.d_rvalA_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // SADR also halts and is not written
    m_set(SADR, 4'd1, 64'h11, RNONE, 64'h0);
    tick();
    m_idle();
    tick();
    check("sadr_halt", 64'(bus.halted_o), 64'h1);
    bus.d_srcA_i = 4'd1;
    #1;
    check("sadr_reg1", bus.d_rvalA_o, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle with a pending write to reg 6
    m_set(SAOK, 4'd6, 64'h66, RNONE, 64'h0);
    tick();
    m_set(SAOK, 4'd6, 64'h666, RNONE, 64'h0);
    tick();
    m_idle();
    bus.d_srcA_i = 4'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("reg6_before_rst", bus.d_rvalA_o, 64'h666);
`else
    check("reg6_before_rst", bus.d_rvalA_o, 64'h66);
`endif
    #1;
    rst = 1'b1;
    #1;
    check("async_reg6", bus.d_rvalA_o, 64'h0);
    check("async_dstE", 64'(bus.W_dstE_o), 64'hF);
    check("async_valE", bus.W_valE_o, 64'h0);
    check("async_stat", 64'(bus.W_stat_o), 64'(SBUB));
    check("async_halted", 64'(bus.halted_o), 64'h0);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_reg6", bus.d_rvalA_o, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
